// File: rtl/mpu_req_arbiter.sv
// Round-robin arbiter funnelling per-core MPU reserve/free requests into a single MPU port.
// Optional WAIT timeout is enabled by defining MPU_ARB_TIMEOUT_EN.
module mpu_req_arbiter #(
    parameter int unsigned CORE_COUNT       = 4,
    parameter int unsigned CORE_ID_WIDTH    = 2,
    parameter int unsigned BLOCK_COUNT_BITS = 8,
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 256
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CORE_COUNT-1:0]                  req_valid,
    output logic [CORE_COUNT-1:0]                  req_ready,
    input  logic [CORE_COUNT-1:0]                  req_fr,
    input  logic [CORE_COUNT*BLOCK_COUNT_BITS-1:0] req_num_blocks,
    input  logic [CORE_COUNT*CORE_COUNT-1:0]       req_read_mask,
    input  logic [CORE_COUNT*CORE_COUNT-1:0]       req_write_mask,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0]       req_addr,
    output logic [CORE_ID_WIDTH-1:0]               mpu_core_id,
    output logic                                   mpu_fr,
    output logic [BLOCK_COUNT_BITS-1:0]            mpu_num_blocks,
    output logic [CORE_COUNT-1:0]                  mpu_read_mask,
    output logic [CORE_COUNT-1:0]                  mpu_write_mask,
    output logic [ADDR_WIDTH-1:0]                  mpu_addr,
    output logic                                   mpu_start,
    input  logic                                   mpu_rdy,
    input  logic [ADDR_WIDTH-1:0]                  mpu_base_addr,
    input  logic                                   mpu_bsy,
    output logic [CORE_COUNT-1:0]                  resp_valid,
    output logic [ADDR_WIDTH-1:0]                  resp_base_addr,
    output logic                                   resp_err,
    output logic                                   arb_bsy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CORE_ID_WIDTH-1:0] LAST_CORE = CORE_ID_WIDTH'(CORE_COUNT - 1);

    state_t                                     state;
    state_t                                     state_next;
    logic [CORE_ID_WIDTH-1:0]                   grant;
    logic [CORE_ID_WIDTH-1:0]                   grant_next;
    logic [CORE_ID_WIDTH-1:0]                   rr_ptr;
    logic [CORE_ID_WIDTH-1:0]                   pick;
    logic                                       found;
    logic                                       timeout_hit;

    logic [CORE_COUNT-1:0]                      pending;
    logic [CORE_COUNT-1:0]                      accept;
    logic [CORE_COUNT-1:0]                      release_vec;
    logic [CORE_COUNT-1:0]                      slot_fr;
    logic [CORE_COUNT-1:0][BLOCK_COUNT_BITS-1:0] slot_nb;
    logic [CORE_COUNT-1:0][CORE_COUNT-1:0]      slot_rm;
    logic [CORE_COUNT-1:0][CORE_COUNT-1:0]      slot_wm;
    logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0]      slot_addr;

    assign req_ready   = ~pending;
    assign accept      = req_valid & ~pending;
    assign release_vec = (state == RESP) ? (CORE_COUNT'(1) << grant) : '0;

    // Slot storage: a slot is only written while free, so the granted slot is stable in service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            slot_fr   <= '0;
            slot_nb   <= '0;
            slot_rm   <= '0;
            slot_wm   <= '0;
            slot_addr <= '0;
        end else begin
            pending <= (pending | accept) & ~release_vec;
            for (int unsigned i = 0; i < CORE_COUNT; i++) begin
                if (accept[i]) begin
                    slot_fr[i]   <= req_fr[i];
                    slot_nb[i]   <= req_num_blocks[i*BLOCK_COUNT_BITS +: BLOCK_COUNT_BITS];
                    slot_rm[i]   <= req_read_mask[i*CORE_COUNT +: CORE_COUNT];
                    slot_wm[i]   <= req_write_mask[i*CORE_COUNT +: CORE_COUNT];
                    slot_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < CORE_COUNT; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % CORE_COUNT;
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = CORE_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        unique case (state)
            IDLE: begin
                if (found && !mpu_bsy) begin
                    grant_next = pick;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (mpu_rdy || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant          <= '0;
            rr_ptr         <= '0;
            resp_base_addr <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == WAIT && mpu_rdy) begin
                resp_base_addr <= mpu_base_addr;
            end else if (state == WAIT && timeout_hit) begin
                resp_base_addr <= '0;
            end
            if (state == RESP) begin
                rr_ptr <= (grant == LAST_CORE) ? '0 : grant + CORE_ID_WIDTH'(1);
            end
        end
    end

`ifdef MPU_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMR_W-1:0] wait_cnt;
    logic             err_q;

    // mpu_rdy on the expiring cycle takes priority over the abort.
    assign timeout_hit = (state == WAIT) && !mpu_rdy &&
                         (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1));
    assign resp_err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + TMR_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (state == RESP) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    always_comb begin
        mpu_core_id    = '0;
        mpu_fr         = 1'b0;
        mpu_num_blocks = '0;
        mpu_read_mask  = '0;
        mpu_write_mask = '0;
        mpu_addr       = '0;
        if (state == ISSUE || state == WAIT) begin
            mpu_core_id    = grant;
            mpu_fr         = slot_fr[grant];
            mpu_num_blocks = slot_nb[grant];
            mpu_read_mask  = slot_rm[grant];
            mpu_write_mask = slot_wm[grant];
            mpu_addr       = slot_addr[grant];
        end
    end

    assign mpu_start  = (state == ISSUE);
    assign resp_valid = release_vec;
    assign arb_bsy    = (state != IDLE);

endmodule

// File: tb/tb_mpu_req_arbiter.sv
// Scoreboard bench for mpu_req_arbiter: issue and response expectations are queued at
// stimulus time and retired as the DUT strobes mpu_start / resp_valid.
module tb_mpu_req_arbiter;

    localparam int unsigned CC  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned NBB = 8;
    localparam int unsigned AW  = 16;
    localparam int unsigned TO  = 8;

    typedef struct packed {
        logic [IDW-1:0] core;
        logic           fr;
        logic [NBB-1:0] nb;
        logic [CC-1:0]  rm;
        logic [CC-1:0]  wm;
        logic [AW-1:0]  addr;
    } issue_t;

    typedef struct packed {
        logic [IDW-1:0] core;
        logic [AW-1:0]  base;
        logic           err;
    } resp_t;

    logic                  clk;
    logic                  rst_n;
    logic [CC-1:0]         req_valid;
    logic [CC-1:0]         req_ready;
    logic [CC-1:0]         req_fr;
    logic [CC*NBB-1:0]     req_num_blocks;
    logic [CC*CC-1:0]      req_read_mask;
    logic [CC*CC-1:0]      req_write_mask;
    logic [CC*AW-1:0]      req_addr;
    logic [IDW-1:0]        mpu_core_id;
    logic                  mpu_fr;
    logic [NBB-1:0]        mpu_num_blocks;
    logic [CC-1:0]         mpu_read_mask;
    logic [CC-1:0]         mpu_write_mask;
    logic [AW-1:0]         mpu_addr;
    logic                  mpu_start;
    logic                  mpu_rdy;
    logic [AW-1:0]         mpu_base_addr;
    logic                  mpu_bsy;
    logic [CC-1:0]         resp_valid;
    logic [AW-1:0]         resp_base_addr;
    logic                  resp_err;
    logic                  arb_bsy;

    logic [CC-1:0]         f_fr;
    logic [NBB-1:0]        f_nb   [CC];
    logic [CC-1:0]         f_rm   [CC];
    logic [CC-1:0]         f_wm   [CC];
    logic [AW-1:0]         f_addr [CC];

    issue_t issue_q[$];
    resp_t  resp_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     rdy_delay = 2;
    bit     mpu_auto  = 1'b1;

    mpu_req_arbiter #(
        .CORE_COUNT      (CC),
        .CORE_ID_WIDTH   (IDW),
        .BLOCK_COUNT_BITS(NBB),
        .ADDR_WIDTH      (AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_fr        (req_fr),
        .req_num_blocks(req_num_blocks),
        .req_read_mask (req_read_mask),
        .req_write_mask(req_write_mask),
        .req_addr      (req_addr),
        .mpu_core_id   (mpu_core_id),
        .mpu_fr        (mpu_fr),
        .mpu_num_blocks(mpu_num_blocks),
        .mpu_read_mask (mpu_read_mask),
        .mpu_write_mask(mpu_write_mask),
        .mpu_addr      (mpu_addr),
        .mpu_start     (mpu_start),
        .mpu_rdy       (mpu_rdy),
        .mpu_base_addr (mpu_base_addr),
        .mpu_bsy       (mpu_bsy),
        .resp_valid    (resp_valid),
        .resp_base_addr(resp_base_addr),
        .resp_err      (resp_err),
        .arb_bsy       (arb_bsy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_fr         = f_fr;
        req_num_blocks = '0;
        req_read_mask  = '0;
        req_write_mask = '0;
        req_addr       = '0;
        for (int i = 0; i < CC; i++) begin
            req_num_blocks[i*NBB +: NBB] = f_nb[i];
            req_read_mask[i*CC +: CC]    = f_rm[i];
            req_write_mask[i*CC +: CC]   = f_wm[i];
            req_addr[i*AW +: AW]         = f_addr[i];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int c, input logic fr, input logic [NBB-1:0] nb,
                        input logic [CC-1:0] rm, input logic [CC-1:0] wm, input logic [AW-1:0] addr);
        f_fr[c]   = fr;
        f_nb[c]   = nb;
        f_rm[c]   = rm;
        f_wm[c]   = wm;
        f_addr[c] = addr;
    endtask

    task automatic expect_txn(input int c, input logic [AW-1:0] base, input logic err, input bit with_resp);
        issue_t e;
        resp_t  r;
        e.core = IDW'(c);
        e.fr   = f_fr[c];
        e.nb   = f_nb[c];
        e.rm   = f_rm[c];
        e.wm   = f_wm[c];
        e.addr = f_addr[c];
        issue_q.push_back(e);
        if (with_resp) begin
            r.core = IDW'(c);
            r.base = base;
            r.err  = err;
            resp_q.push_back(r);
        end
    endtask

    task automatic fire(input logic [CC-1:0] cores);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = cores;
        while (((req_ready & cores) != cores) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", 64'(req_ready & cores), 64'(cores));
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((issue_q.size() != 0 || resp_q.size() != 0 || arb_bsy) && n < bound);
        check_eq("drain", {32'(issue_q.size()), 31'(resp_q.size()), arb_bsy}, 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        issue_q.delete();
        resp_q.delete();
        rst_n = 1'b1;
    endtask

    // MPU model: answers each start after rdy_delay cycles with the base the bench expects.
    initial begin
        mpu_rdy       = 1'b0;
        mpu_base_addr = 16'hdead;
        forever begin
            @(negedge clk);
            if (rst_n && mpu_start && mpu_auto) begin
                repeat (rdy_delay) @(negedge clk);
                if (resp_q.size() != 0) mpu_base_addr = resp_q[0].base;
                mpu_rdy = 1'b1;
                @(negedge clk);
                mpu_rdy       = 1'b0;
                mpu_base_addr = 16'($urandom);
            end
        end
    end

    // Monitor: retires scoreboard entries and checks field stability while waiting.
    initial begin
        issue_t cur;
        resp_t  r;
        int     start_cyc;
        bit     in_svc;
        in_svc    = 1'b0;
        start_cyc = 0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_svc = 1'b0;
            end else begin
                if (mpu_start) begin
                    if (issue_q.size() == 0) begin
                        check_eq("unexpected_start", 64'(mpu_start), 64'(0));
                    end else begin
                        cur = issue_q.pop_front();
                        check_eq("start_id",   64'(mpu_core_id),    64'(cur.core));
                        check_eq("start_fr",   64'(mpu_fr),         64'(cur.fr));
                        check_eq("start_nb",   64'(mpu_num_blocks), 64'(cur.nb));
                        check_eq("start_rm",   64'(mpu_read_mask),  64'(cur.rm));
                        check_eq("start_wm",   64'(mpu_write_mask), 64'(cur.wm));
                        check_eq("start_addr", 64'(mpu_addr),       64'(cur.addr));
                        in_svc    = 1'b1;
                        start_cyc = cyc;
                    end
                end else if (arb_bsy && resp_valid == '0 && in_svc) begin
                    check_eq("wait_id",   64'(mpu_core_id), 64'(cur.core));
                    check_eq("wait_addr", 64'(mpu_addr),    64'(cur.addr));
                end else if (!arb_bsy) begin
                    check_eq("idle_outputs",
                             64'({mpu_core_id, mpu_fr, mpu_num_blocks, mpu_read_mask,
                                  mpu_write_mask, mpu_addr, mpu_start, resp_err, resp_valid}),
                             64'(0));
                end
                if (resp_valid != '0) begin
                    if (resp_q.size() == 0) begin
                        check_eq("unexpected_resp", 64'(resp_valid), 64'(0));
                    end else begin
                        r = resp_q.pop_front();
                        check_eq("resp_valid", 64'(resp_valid),     64'(CC'(1) << r.core));
                        check_eq("resp_base",  64'(resp_base_addr), 64'(r.base));
                        check_eq("resp_err",   64'(resp_err),       64'(r.err));
                        check_eq("resp_latency", 64'(cyc - start_cyc),
                                 64'(r.err ? TO + 1 : 32'(rdy_delay) + 1));
                    end
                    in_svc = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        mpu_bsy   = 1'b0;
        f_fr      = '0;
        for (int i = 0; i < CC; i++) load(i, 1'b0, '0, '0, '0, '0);

        // Reset state
        @(negedge clk);
        check_eq("rst_ready",     64'(req_ready),      64'(4'hf));
        check_eq("rst_arb_bsy",   64'(arb_bsy),        64'(0));
        check_eq("rst_resp",      64'(resp_valid),     64'(0));
        check_eq("rst_start",     64'(mpu_start),      64'(0));
        check_eq("rst_base",      64'(resp_base_addr), 64'(0));
        check_eq("rst_err",       64'(resp_err),       64'(0));
        check_eq("rst_core_id",   64'(mpu_core_id),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single reserve from core 2
        rdy_delay = 4;
        load(2, 1'b1, 8'd5, 4'b0011, 4'b0100, 16'h0000);
        expect_txn(2, 16'h0040, 1'b0, 1'b1);
        fire(4'b0100);
        drain(100);
        check_eq("hold_base", 64'(resp_base_addr), 64'(16'h0040));

        // Simultaneous requests from cores 0,1,3 after reset, then rr_ptr back at 0
        do_reset();
        rdy_delay = 2;
        load(0, 1'b1, 8'd1, 4'b0001, 4'b0001, 16'h0000);
        load(1, 1'b1, 8'd2, 4'b0010, 4'b0010, 16'h0000);
        load(3, 1'b1, 8'd3, 4'b1000, 4'b1000, 16'h0000);
        expect_txn(0, 16'h0100, 1'b0, 1'b1);
        expect_txn(1, 16'h0110, 1'b0, 1'b1);
        expect_txn(3, 16'h0130, 1'b0, 1'b1);
        fire(4'b1011);
        drain(200);
        load(1, 1'b0, 8'd7, 4'b1111, 4'b0000, 16'h0a10);
        load(3, 1'b0, 8'd9, 4'b0000, 4'b1111, 16'h0a30);
        expect_txn(1, 16'h0111, 1'b0, 1'b1);
        expect_txn(3, 16'h0131, 1'b0, 1'b1);
        fire(4'b1010);
        drain(200);

        // Free from core 1 held off by mpu_bsy
        rdy_delay = 1;
        mpu_bsy = 1'b1;
        load(1, 1'b0, 8'd4, 4'b0110, 4'b0010, 16'h0080);
        fire(4'b0010);
        repeat (10) @(negedge clk);
        check_eq("bsy_arb_idle", 64'(arb_bsy),      64'(0));
        check_eq("bsy_pending",  64'(req_ready[1]), 64'(0));
        expect_txn(1, 16'h0055, 1'b0, 1'b1);
        mpu_bsy = 1'b0;
        drain(100);

        // Core 0 re-requests while its slot is pending
        rdy_delay = 3;
        mpu_bsy = 1'b1;
        load(0, 1'b1, 8'd11, 4'b0001, 4'b0011, 16'h0200);
        fire(4'b0001);
        @(negedge clk);
        check_eq("pending_ready0", 64'(req_ready[0]), 64'(0));
        expect_txn(0, 16'h0300, 1'b0, 1'b1);
        load(0, 1'b0, 8'd12, 4'b1001, 4'b0110, 16'h0400);
        expect_txn(0, 16'h0310, 1'b0, 1'b1);
        mpu_bsy = 1'b0;
        fire(4'b0001);
        drain(200);

        // MPU never answers
        mpu_auto = 1'b0;
        load(2, 1'b1, 8'd6, 4'b0100, 4'b0100, 16'h0000);
`ifdef MPU_ARB_TIMEOUT_EN
        expect_txn(2, 16'h0000, 1'b1, 1'b1);
        fire(4'b0100);
        drain(100);
        check_eq("timeout_ready2", 64'(req_ready[2]), 64'(1));
`else
        expect_txn(2, 16'h0000, 1'b0, 1'b0);
        fire(4'b0100);
        repeat (30) @(negedge clk);
        check_eq("stuck_arb_bsy", 64'(arb_bsy),      64'(1));
        check_eq("stuck_ready2",  64'(req_ready[2]), 64'(0));
        check_eq("stuck_err",     64'(resp_err),     64'(0));
        do_reset();
`endif
        mpu_auto = 1'b1;

        // Reset while core 3 is in WAIT discards the request
        do_reset();
        mpu_auto = 1'b0;
        load(3, 1'b1, 8'd2, 4'b1000, 4'b1000, 16'h0000);
        expect_txn(3, 16'h0000, 1'b0, 1'b0);
        fire(4'b1000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(arb_bsy && !mpu_start && resp_valid == '0) && n < 50);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_wait", 64'({arb_bsy, mpu_core_id}), 64'({1'b1, 2'd3}));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_ready", 64'(req_ready),  64'(4'hf));
        check_eq("async_bsy",   64'(arb_bsy),    64'(0));
        check_eq("async_resp",  64'(resp_valid), 64'(0));
        check_eq("async_start", 64'(mpu_start),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post_rst_ready", 64'(req_ready), 64'(4'hf));
        check_eq("queues_empty", 64'(issue_q.size() + resp_q.size()), 64'(0));
        mpu_auto = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
